// File: rtl/axi_stream_wr_dma_pkg.sv
// Shared AXI definitions for the stream-to-AXI write DMA.
// Holds the AXI burst/response encodings, the 4 KB page constant, the DMA
// state type and a small unsigned-min helper used by the burst calculator.
package axi_stream_wr_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  // Bufferable + modifiable normal memory.
  localparam logic [3:0] AXI_CACHE_WR   = 4'b0011;
  localparam logic [2:0] AXI_PROT_WR    = 3'b000;
  // AXI bursts must never cross a 4 KB page.
  localparam int unsigned AXI_4K_BOUNDARY = 4096;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } dma_state_t;

  function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_stream_wr_dma_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA and a memory slave.
// Ports: master modport is the DMA side (drives aw*/w*/bready),
//        slave modport is the memory side (drives awready/wready/b*).
interface axi_stream_wr_dma_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 13,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_burst_len_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST_LEN,
// beats left before the next 4 KB page boundary).
// Ports: addr (beat-aligned byte address), remaining (beats still to send),
//        beats (1..256 when remaining != 0).
module axi_burst_len_calc
  import axi_stream_wr_dma_pkg::*;
#(
  parameter int ADDR_WIDTH    = 13,
  parameter int LEN_WIDTH     = 16,
  parameter int STRB_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [8:0]            beats
);
  localparam int unsigned SIZE_LOG2 = $clog2(STRB_WIDTH);

  logic [31:0] page_off;
  logic [31:0] to_boundary;
  logic [31:0] limit;

  always_comb begin
    page_off    = 32'(addr) & 32'(AXI_4K_BOUNDARY - 1);
    // Address is beat aligned, so the shift is exact.
    to_boundary = (32'(AXI_4K_BOUNDARY) - page_off) >> SIZE_LOG2;
    limit       = umin(32'(remaining), 32'(MAX_BURST_LEN));
    limit       = umin(limit, to_boundary);
    beats       = 9'(limit);
  end

endmodule

// File: rtl/axi_stream_wr_dma.sv
// Stream-to-AXI write DMA. Accepts a (start address, beat count) command,
// splits it into INCR bursts that respect MAX_BURST_LEN and 4 KB pages,
// forwards the input stream onto the W channel and collects B responses.
// One burst outstanding at a time.
// Ports: clk/rst (sync, active high); cmd_valid/cmd_ready/cmd_addr/cmd_len
//        command handshake; s_axis_tdata/tvalid/tready input stream;
//        m_axi AXI write master; done (1-cycle pulse), error (sticky bad
//        bresp, cleared by next command), busy (not idle).
module axi_stream_wr_dma
  import axi_stream_wr_dma_pkg::*;
#(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 13,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 4,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  axi_stream_wr_dma_if.master   m_axi,
  output logic                  done,
  output logic                  error,
  output logic                  busy
);
  localparam int unsigned SIZE_LOG2 = $clog2(STRB_WIDTH);

  dma_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [8:0]            beats_q;
  logic [7:0]            beat_cnt;
  logic [8:0]            burst_beats;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic                  w_fire;

  assign aligned_addr = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);

  axi_burst_len_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .STRB_WIDTH    (STRB_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_burst_len_calc (
    .addr      (addr_q),
    .remaining (remaining_q),
    .beats     (burst_beats)
  );

  // Fixed AW attributes.
  assign m_axi.awid    = '0;
  assign m_axi.awsize  = 3'(SIZE_LOG2);
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AXI_CACHE_WR;
  assign m_axi.awprot  = AXI_PROT_WR;

  // W channel is a direct pass-through of the stream while in DATA.
  assign m_axi.wdata   = s_axis_tdata;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = (state == S_DATA) && s_axis_tvalid;
  assign s_axis_tready = (state == S_DATA) && m_axi.wready;
  assign m_axi.wlast   = (state == S_DATA) && (beat_cnt == m_axi.awlen);
  assign w_fire        = m_axi.wvalid && m_axi.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_axi.awvalid <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.awlen   <= '0;
      m_axi.bready  <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_q       <= '0;
      beat_cnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            error       <= 1'b0;
            addr_q      <= aligned_addr;
            remaining_q <= cmd_len;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_ADDR;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          // First ADDR cycle registers the burst, then holds it until awready.
          if (!m_axi.awvalid) begin
            m_axi.awaddr  <= addr_q;
            m_axi.awlen   <= 8'(burst_beats - 9'd1);
            beats_q       <= burst_beats;
            m_axi.awvalid <= 1'b1;
          end else if (m_axi.awready) begin
            m_axi.awvalid <= 1'b0;
            beat_cnt      <= '0;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_axi.wlast) begin
              state        <= S_RESP;
              m_axi.bready <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            if (m_axi.bresp != AXI_RESP_OKAY) error <= 1'b1;
            addr_q      <= addr_q + ADDR_WIDTH'(32'(beats_q) << SIZE_LOG2);
            remaining_q <= remaining_q - LEN_WIDTH'(beats_q);
            if (remaining_q == LEN_WIDTH'(beats_q)) begin
              state     <= S_IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              state <= S_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_stream_wr_dma.md
AXI_STREAM_WR_DMA -- requirements
Module: axi_stream_wr_dma

Interface
REQ-001 Parameter DATA_WIDTH, default 256: AXI and stream data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 13: AXI byte-address width.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8: write-strobe width.
REQ-004 Parameter ID_WIDTH, default 4: AXI ID width.
REQ-005 Parameter MAX_BURST_LEN, default 16: maximum beats per burst, range 1..256.
REQ-006 Parameter LEN_WIDTH, default 16: command length field width, in beats.
REQ-007 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-008 clk  input  1  sole clock; all state changes on its rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-011 cmd_addr  input  ADDR_WIDTH  start byte address; bits below log2(STRB_WIDTH) are ignored and treated as zero.
REQ-012 cmd_len  input  LEN_WIDTH  transfer length in beats.
REQ-013 s_axis_tdata / s_axis_tvalid / s_axis_tready  in / in / out  DATA_WIDTH / 1 / 1  input stream.
REQ-014 m_axi_aw*  out (awready in)  standard widths  write-address channel: id, addr, len[7:0], size[2:0], burst[1:0], lock, cache[3:0], prot[2:0], valid, ready.
REQ-015 m_axi_w*  out (wready in)  standard widths  write-data channel: data, strb, last, valid, ready.
REQ-016 m_axi_b*  in (bready out)  standard widths  write-response channel: id, resp[1:0], valid, ready.
REQ-017 done  output  1  one-cycle pulse at command completion.
REQ-018 error  output  1  sticky flag, set when any burst returns bresp != 2'b00; cleared on acceptance of the next command.
REQ-019 busy  output  1  high whenever state != IDLE.

Function
REQ-020 States SHALL be IDLE, ADDR, DATA, RESP; only one burst outstanding.
REQ-021 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch aligned address and remaining length; cmd_len==0 -> done pulse next cycle, stay IDLE, no AXI traffic; else -> ADDR.
REQ-022 Burst length = min(remaining, MAX_BURST_LEN, beats left before the next 4 KB boundary); computed in ADDR and registered.
REQ-023 ADDR: awvalid=1, awlen=beats-1, awsize=log2(STRB_WIDTH), awburst=INCR (2'b01), awlock=0, awcache=4'b0011, awprot=3'b000, awid=0; on awready -> DATA.
REQ-024 awvalid and all aw* fields SHALL be registered and held stable until awready.
REQ-025 DATA: wvalid=s_axis_tvalid, s_axis_tready=m_axi_wready, wdata=s_axis_tdata, wstrb all ones, wlast high on the final beat of the burst; s_axis_tready=0 in all other states.
REQ-026 On the final W beat handshake -> RESP; bready=1 only in RESP.
REQ-027 RESP: on bvalid, OR (bresp!=0) into error, advance address by beats*STRB_WIDTH, reduce remaining; remaining==0 -> IDLE with done pulse the same cycle IDLE is entered; else -> ADDR.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-029 A stream stall (tvalid low) mid-burst SHALL hold wvalid low without dropping or duplicating beats; a wready stall SHALL hold tready low.
REQ-030 Throughput in DATA SHALL be one beat per cycle when tvalid and wready are both high.

Reset
REQ-031 On rst: state=IDLE; awvalid, bready, done, error, busy = 0; cmd_ready=1 from the first cycle after reset; s_axis_tready=0; any in-flight command is abandoned.

Structure
REQ-032 AXI burst and response encodings (INCR, OKAY) and the 4 KB boundary constant SHALL live in the shared axi package.
REQ-033 The burst-length calculation SHALL be one sub-module, axi_burst_len_calc, which is combinational with parameterised widths.

Verification
REQ-034 cmd_addr=0x000, cmd_len=40, MAX_BURST_LEN=16, always-ready slave -> bursts awlen=15,15,7 at 0x000, 0x200, 0x400; done once; error=0.
REQ-035 cmd_addr=0xFC0, cmd_len=4 (32-byte beats) -> awlen=1 at 0xFC0, then awlen=1 at 0x1000; no burst crosses the 4 KB boundary.
REQ-036 Random tvalid and wready gaps, cmd_len=100 -> memory contents equal the stream in order; wlast count equals burst count.
REQ-037 Slave returns bresp=2'b10 on the second burst -> error=1 after completion; the next command clears it.
REQ-038 cmd_len=0 -> done pulse one cycle later; no awvalid asserted.
REQ-039 rst asserted mid-DATA -> next cycle busy=0, awvalid=0, s_axis_tready=0; a new command completes correctly.
